udp_text_shadow_buffer: RTL and testbench

- Sits between the Ethernet UDP receive RAM and the OSD character renderer, in the pixel clock domain.
- On each received UDP text packet it copies the payload from the receive RAM into the back bank of a double-buffered character RAM.
- Bytes after a NUL terminator are padded with a fill character.
- Banks swap only on a vsync leading edge, so the displayed text never tears mid-frame.

---
 rtl/udp_text_shadow_buffer_pkg.sv | 9 +
 rtl/udp_text_shadow_buffer_osd_dp_ram.sv | 24 ++
 rtl/udp_text_shadow_buffer.sv | 156 +++++++++++++++
 tb/tb_udp_text_shadow_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/udp_text_shadow_buffer_pkg.sv
// Shared OSD text definitions: copy FSM states and character constants,
// also used by the OSD renderer.
package udp_text_shadow_buffer_pkg;
  typedef enum logic [1:0] {IDLE, COPY, FILL, WAIT_VS} osd_state_e;

  localparam int         CHAR_ADDR_W = 11;
  localparam logic [7:0] FONT_FILL   = 8'h20;
  localparam logic [7:0] NUL         = 8'h00;
endpackage

// File: rtl/udp_text_shadow_buffer_osd_dp_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// Only the read-data register is reset, so the array still maps onto block RAM.
module osd_dp_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end
endmodule

// File: rtl/udp_text_shadow_buffer.sv
// Copies a NUL-terminated UDP text payload into the back bank of a
// double-buffered character RAM and swaps banks on a vsync leading edge.
module udp_text_shadow_buffer
  import udp_text_shadow_buffer_pkg::*;
#(
  parameter int         ADDR_W    = CHAR_ADDR_W,
  parameter int         MAX_CHARS = 2048,
  parameter logic [7:0] FILL_CHAR = FONT_FILL,
  parameter logic       VS_POL    = 1'b1
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              udp_rec_data_valid,
  output logic [ADDR_W-1:0] src_ram_addr,
  input  logic [7:0]        src_ram_rdata,
  input  logic              vs,
  input  logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        q,
  output logic              text_valid,
  output logic [ADDR_W:0]   char_count
);
  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_CHARS - 1);
  localparam logic [ADDR_W-1:0] TOP_IDX  = '1;
  localparam logic              NO_FILL  = (MAX_CHARS >= DEPTH);

  osd_state_e        state_q, state_d;
  logic              front_q, front_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic              rd_vld_q;
  logic [ADDR_W:0]   back_cnt_q, back_cnt_d;
  logic [ADDR_W:0]   char_cnt_q, char_cnt_d;
  logic              text_valid_q, text_valid_d;
  logic              vs_q;
  logic              vs_rise;
  logic              we;
  logic [7:0]        wdata;

  assign vs_rise = (vs == VS_POL) && (vs_q != VS_POL);

  always_comb begin
    state_d      = state_q;
    front_d      = front_q;
    pending_d    = pending_q;
    rd_idx_d     = rd_idx_q;
    wr_idx_d     = wr_idx_q;
    back_cnt_d   = back_cnt_q;
    char_cnt_d   = char_cnt_q;
    text_valid_d = text_valid_q;
    we           = 1'b0;
    wdata        = FILL_CHAR;
    unique case (state_q)
      IDLE: begin
        if (udp_rec_data_valid) begin
          state_d  = COPY;
          rd_idx_d = '0;
          wr_idx_d = '0;
        end
      end
      COPY: begin
        rd_idx_d = rd_idx_q + 1'b1;
        if (udp_rec_data_valid) pending_d = 1'b1;
        // rd_vld_q marks the cycle the byte addressed last cycle is on src_ram_rdata
        if (rd_vld_q) begin
          we = 1'b1;
          if (src_ram_rdata == NUL) begin
            back_cnt_d = {1'b0, wr_idx_q};
            if (wr_idx_q == TOP_IDX) state_d = WAIT_VS;
            else begin
              state_d  = FILL;
              wr_idx_d = wr_idx_q + 1'b1;
            end
          end else begin
            wdata = src_ram_rdata;
            if (wr_idx_q == LAST_IDX) begin
              back_cnt_d = (ADDR_W+1)'(MAX_CHARS);
              if (NO_FILL) state_d = WAIT_VS;
              else begin
                state_d  = FILL;
                wr_idx_d = wr_idx_q + 1'b1;
              end
            end else begin
              wr_idx_d = wr_idx_q + 1'b1;
            end
          end
        end
      end
      FILL: begin
        we = 1'b1;
        if (udp_rec_data_valid) pending_d = 1'b1;
        if (wr_idx_q == TOP_IDX) state_d = WAIT_VS;
        else                     wr_idx_d = wr_idx_q + 1'b1;
      end
      WAIT_VS: begin
        if (udp_rec_data_valid) pending_d = 1'b1;
        if (vs_rise) begin
          front_d      = ~front_q;
          char_cnt_d   = back_cnt_q;
          text_valid_d = 1'b1;
          pending_d    = 1'b0;
          // a pulse landing on the swap cycle restarts the copy rather than being lost
          if (pending_q || udp_rec_data_valid) begin
            state_d  = COPY;
            rd_idx_d = '0;
            wr_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      front_q      <= 1'b0;
      pending_q    <= 1'b0;
      rd_idx_q     <= '0;
      wr_idx_q     <= '0;
      rd_vld_q     <= 1'b0;
      back_cnt_q   <= '0;
      char_cnt_q   <= '0;
      text_valid_q <= 1'b0;
      vs_q         <= VS_POL;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      pending_q    <= pending_d;
      rd_idx_q     <= rd_idx_d;
      wr_idx_q     <= wr_idx_d;
      rd_vld_q     <= (state_q == COPY);
      back_cnt_q   <= back_cnt_d;
      char_cnt_q   <= char_cnt_d;
      text_valid_q <= text_valid_d;
      vs_q         <= vs;
    end
  end

  osd_dp_ram #(.ADDR_W(ADDR_W + 1)) u_ram (
    .clk   (pclk),
    .rst_n (rst_n),
    .we    (we && rst_n),
    .waddr ({~front_q, wr_idx_q}),
    .wdata (wdata),
    .raddr ({front_q, ram_addr}),
    .rdata (q)
  );

  assign src_ram_addr = rd_idx_q;
  assign text_valid   = text_valid_q;
  assign char_count   = char_cnt_q;
endmodule

// File: tb/tb_udp_text_shadow_buffer.sv
// Directed-sequence bench with random packets, checked against a packet-image
// model built directly from the terminator/fill rules.
module tb_udp_text_shadow_buffer;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic          pclk = 1'b0;
  logic          rst_n;
  logic          udp_rec_data_valid;
  logic [AW-1:0] src_ram_addr;
  logic [7:0]    src_ram_rdata;
  logic          vs;
  logic [AW-1:0] ram_addr;
  logic [7:0]    q;
  logic          text_valid;
  logic [AW:0]   char_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] src_mem [DEPTH];
  logic [7:0] img [4][DEPTH];
  int         cnt [4];
  int         shown;

  udp_text_shadow_buffer dut (
    .pclk               (pclk),
    .rst_n              (rst_n),
    .udp_rec_data_valid (udp_rec_data_valid),
    .src_ram_addr       (src_ram_addr),
    .src_ram_rdata      (src_ram_rdata),
    .vs                 (vs),
    .ram_addr           (ram_addr),
    .q                  (q),
    .text_valid         (text_valid),
    .char_count         (char_count)
  );

  always #5 pclk = ~pclk;

  // Source RAM: synchronous read, data one cycle after the address
  always @(posedge pclk) src_ram_rdata <= src_mem[src_ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_text(input string s);
    for (int i = 0; i < DEPTH; i++) src_mem[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  // Random non-zero bytes with a NUL at nul_pos (none if nul_pos >= DEPTH)
  task automatic load_rand(input int nul_pos);
    for (int i = 0; i < DEPTH; i++) src_mem[i] = 8'($urandom_range(1, 255));
    if (nul_pos < DEPTH) src_mem[nul_pos] = 8'h00;
  endtask

  // Expected display image: bytes up to the first NUL, fill character after it
  task automatic capture(input int slot);
    int n;
    n = DEPTH;
    for (int i = 0; i < DEPTH; i++) if (src_mem[i] == 8'h00) begin n = i; break; end
    for (int i = 0; i < DEPTH; i++) img[slot][i] = (i < n) ? src_mem[i] : 8'h20;
    cnt[slot] = n;
  endtask

  task automatic pulse();
    @(negedge pclk) udp_rec_data_valid = 1'b1;
    @(negedge pclk) udp_rec_data_valid = 1'b0;
  endtask

  task automatic vs_pulse();
    @(negedge pclk) vs = 1'b1;
    @(negedge pclk) vs = 1'b0;
  endtask

  task automatic wait_copy();
    repeat (2100) @(negedge pclk);
  endtask

  task automatic read_chk(input string tag, input int a, input logic [7:0] exp);
    @(negedge pclk) ram_addr = AW'(a);
    @(negedge pclk) chk(tag, 32'(q), 32'(exp));
  endtask

  task automatic sample_chk(input int n);
    int c;
    c = cnt[shown];
    read_chk("q_first", 0, img[shown][0]);
    read_chk("q_last", DEPTH - 1, img[shown][DEPTH-1]);
    if (c > 0)     read_chk("q_before_nul", c - 1, img[shown][c-1]);
    if (c < DEPTH) read_chk("q_at_nul", c, 8'h20);
    for (int k = 0; k < n; k++) begin
      int a;
      a = int'($urandom_range(0, DEPTH - 1));
      read_chk("q_rand", a, img[shown][a]);
    end
  endtask

  task automatic full_chk(input string tag);
    for (int a = 0; a < DEPTH; a++) read_chk(tag, a, img[shown][a]);
  endtask

  task automatic show_chk(input int slot);
    shown = slot;
    chk("text_valid", 32'(text_valid), 32'd1);
    chk("char_count", 32'(char_count), 32'(cnt[slot]));
  endtask

  initial begin
    rst_n = 1'b0; udp_rec_data_valid = 1'b0; vs = 1'b0; ram_addr = '0;
    for (int i = 0; i < DEPTH; i++) src_mem[i] = 8'h00;
    repeat (3) @(negedge pclk);
    chk("rst_text_valid", 32'(text_valid), 32'd0);
    chk("rst_char_count", 32'(char_count), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_src_addr", 32'(src_ram_addr), 32'd0);
    rst_n = 1'b1;

    // Reset mid-COPY aborts; a later vs edge must not swap
    load_rand(1500);
    pulse();
    repeat (20) @(negedge pclk);
    rst_n = 1'b0;
    @(negedge pclk);
    chk("abort_text_valid", 32'(text_valid), 32'd0);
    chk("abort_char_count", 32'(char_count), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_src_addr", 32'(src_ram_addr), 32'd0);
    rst_n = 1'b1;
    wait_copy();
    vs_pulse();
    repeat (2) @(negedge pclk);
    chk("abort_no_swap_tv", 32'(text_valid), 32'd0);
    chk("abort_no_swap_cnt", 32'(char_count), 32'd0);

    // HELLO
    load_text("HELLO");
    capture(0);
    pulse();
    wait_copy();
    vs_pulse();
    show_chk(0);
    chk("hello_count_const", 32'(char_count), 32'd5);
    read_chk("hello_0", 0, 8'h48);
    read_chk("hello_1", 1, 8'h45);
    read_chk("hello_4", 4, 8'h4F);
    read_chk("hello_5", 5, 8'h20);
    full_chk("hello_img");

    // NUL at index 0: all fill
    load_rand(0);
    capture(1);
    pulse();
    wait_copy();
    vs_pulse();
    show_chk(1);
    full_chk("nul0_img");

    // No NUL at all: MAX_CHARS bytes, no fill
    load_rand(DEPTH);
    capture(2);
    pulse();
    wait_copy();
    vs_pulse();
    show_chk(2);
    chk("full_count_const", 32'(char_count), 32'd2048);
    sample_chk(64);

    // Packet B pulsed while A waits for vsync
    load_rand(int'($urandom_range(1, 2000)));
    capture(0);
    pulse();
    wait_copy();
    load_rand(int'($urandom_range(1, 2000)));
    capture(1);
    pulse();
    vs_pulse();
    show_chk(0);
    sample_chk(32);
    wait_copy();
    vs_pulse();
    show_chk(1);
    sample_chk(32);

    // vs edge during COPY is ignored
    load_rand(int'($urandom_range(300, 2000)));
    capture(2);
    pulse();
    repeat (10) @(negedge pclk);
    vs_pulse();
    chk("vs_in_copy_count", 32'(char_count), 32'(cnt[1]));
    sample_chk(16);
    wait_copy();
    vs_pulse();
    show_chk(2);
    sample_chk(32);

    // Three pulses in one COPY collapse into exactly one extra copy
    load_rand(int'($urandom_range(200, 1000)));
    capture(0);
    pulse();
    repeat (3) begin
      repeat (5) @(negedge pclk);
      pulse();
    end
    wait_copy();
    load_rand(300);
    capture(1);
    vs_pulse();
    show_chk(0);
    sample_chk(16);
    wait_copy();
    vs_pulse();
    show_chk(1);
    load_rand(700);
    sample_chk(16);
    wait_copy();
    vs_pulse();
    repeat (2) @(negedge pclk);
    show_chk(1);
    sample_chk(32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
